// File: rtl/triple_sample_capture.sv
// Triple-sample capture front end for the majority voter: samples din three times,
// SAMPLE_GAP clocks apart, and hands A,B,C out over a valid/ready handshake.
module triple_sample_capture #(
    parameter int SAMPLE_GAP = 4,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             ready,
    input  logic             clear_err,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             valid,
    output logic             disagree,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP1 = 2'd1,
        ST_GAP2 = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(SAMPLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO   = {ERR_W{1'b0}};

    // High when the three samples are not unanimous.
    function automatic logic samples_differ(input logic s0, input logic s1, input logic s2);
        return ~((s0 == s1) && (s1 == s2));
    endfunction

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             a_r, a_next_s;
    logic             b_r, b_next_s;
    logic             c_r, c_next_s;
    logic             valid_r, valid_next_s;
    logic             disagree_r, disagree_next_s;
    logic [ERR_W-1:0] err_cnt_r, err_next_s;
    logic             capture_done_s;

    // Next-state, gap countdown and sample capture decode.
    always_comb begin
        next_state_s    = state_r;
        cnt_next_s      = cnt_r;
        a_next_s        = a_r;
        b_next_s        = b_r;
        c_next_s        = c_r;
        valid_next_s    = valid_r;
        disagree_next_s = disagree_r;
        capture_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_next_s     = din;
                    cnt_next_s   = GAP_RELOAD;
                    next_state_s = ST_GAP1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GAP1: begin
                if (cnt_r == CNT_ZERO) begin
                    b_next_s     = din;
                    cnt_next_s   = GAP_RELOAD;
                    next_state_s = ST_GAP2;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_GAP2: begin
                if (cnt_r == CNT_ZERO) begin
                    c_next_s        = din;
                    valid_next_s    = 1'b1;
                    disagree_next_s = samples_differ(a_r, b_r, din);
                    capture_done_s  = 1'b1;
                    next_state_s    = ST_HOLD;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // A new start is only seen once we are back in IDLE.
                if (ready) begin
                    valid_next_s = 1'b0;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Saturating disagreement counter; clear has priority over the increment.
    always_comb begin
        err_next_s = err_cnt_r;
        if (clear_err) begin
            err_next_s = ERR_ZERO;
        end else if (capture_done_s && disagree_next_s && (err_cnt_r != ERR_MAX)) begin
            err_next_s = err_cnt_r + ERR_W'(1);
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            a_r        <= 1'b0;
            b_r        <= 1'b0;
            c_r        <= 1'b0;
            valid_r    <= 1'b0;
            disagree_r <= 1'b0;
            err_cnt_r  <= ERR_ZERO;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            a_r        <= a_next_s;
            b_r        <= b_next_s;
            c_r        <= c_next_s;
            valid_r    <= valid_next_s;
            disagree_r <= disagree_next_s;
            err_cnt_r  <= err_next_s;
        end
    end

    assign A        = a_r;
    assign B        = b_r;
    assign C        = c_r;
    assign valid    = valid_r;
    assign disagree = disagree_r;
    assign err_cnt  = err_cnt_r;
    assign busy     = (state_r != ST_IDLE);

endmodule
